// File: rtl/id_ctrl_pipe_pkg.sv
// id_ctrl_pipe_pkg: opcodes, ALU operations and halt FSM states shared by the decode stage
package id_ctrl_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
        OP_LW, OP_SW, OP_LHB, OP_LLB, OP_B, OP_JAL, OP_JR, OP_HLT
    } opcode_t;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_NOR = 4'h3;
    localparam logic [3:0] ALU_SLL = 4'h4;
    localparam logic [3:0] ALU_SRL = 4'h5;
    localparam logic [3:0] ALU_SRA = 4'h6;
    localparam logic [3:0] ALU_LHB = 4'h7;
    localparam logic [3:0] ALU_NOP = 4'hF;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/id_decode.sv
// id_decode: purely combinational instruction-to-control-bundle decoder
module id_decode import id_ctrl_pipe_pkg::*; #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int LINK_REG = 15
) (
    input  logic [DATA_W-1:0] instr,
    output logic [REG_AW-1:0] rdReg1,
    output logic [REG_AW-1:0] rdReg2,
    output logic [REG_AW-1:0] wrReg,
    output logic              rdEn1,
    output logic              rdEn2,
    output logic              wrRegEn,
    output logic              memRd,
    output logic              memWr,
    output logic              mem2reg,
    output logic              sawBr,
    output logic              sawJ,
    output logic              addz,
    output logic              aluSrc,
    output logic [3:0]        aluOp,
    output logic [3:0]        shAmt
);

    opcode_t           op;
    logic [REG_AW-1:0] rd, rs, rt;

    assign op      = opcode_t'(instr[DATA_W-1 -: 4]);
    assign rd      = instr[3*REG_AW-1 -: REG_AW];
    assign rs      = instr[2*REG_AW-1 -: REG_AW];
    assign rt      = instr[REG_AW-1:0];
    assign rdEn1   = !(op inside {OP_HLT, OP_LLB, OP_B, OP_JAL});
    assign rdEn2   = op inside {OP_ADD, OP_ADDZ, OP_SUB, OP_AND, OP_NOR};
    assign wrRegEn = !(op inside {OP_HLT, OP_SW, OP_B, OP_JR});
    assign memRd   = op == OP_LW;
    assign memWr   = op == OP_SW;
    assign mem2reg = op == OP_LW;
    assign sawBr   = op == OP_B;
    assign sawJ    = op inside {OP_JAL, OP_JR};
    assign addz    = op == OP_ADDZ;
    assign aluSrc  = rdEn2;
    assign rdReg1  = (op inside {OP_LHB, OP_SW}) ? rd : rs;
    assign rdReg2  = rt;
    assign wrReg   = (op == OP_JAL) ? REG_AW'(LINK_REG) : rd;
    assign shAmt   = instr[3:0];

    // ADDZ shares the adder; its Z-flag gating happens in EX via addz
    always_comb begin
        aluOp = ALU_NOP;
        case (op)
            OP_ADD, OP_ADDZ: aluOp = ALU_ADD;
            OP_SUB:          aluOp = ALU_SUB;
            OP_AND:          aluOp = ALU_AND;
            OP_NOR:          aluOp = ALU_NOR;
            OP_SLL:          aluOp = ALU_SLL;
            OP_SRL:          aluOp = ALU_SRL;
            OP_SRA:          aluOp = ALU_SRA;
            OP_LHB:          aluOp = ALU_LHB;
            default:         aluOp = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: ID stage with ID/EX register, RAW hazard stalls, flush handling and HLT drain
module id_ctrl_pipe import id_ctrl_pipe_pkg::*; #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int LINK_REG  = 15,
    parameter int HAZ_MODE  = 1,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] if_instr,
    input  logic              if_vld,
    input  logic              ex_flush,
    output logic              id_stall,
    output logic              ex_vld,
    output logic [REG_AW-1:0] ex_rdReg1,
    output logic [REG_AW-1:0] ex_rdReg2,
    output logic [REG_AW-1:0] ex_wrReg,
    output logic              ex_rdEn1,
    output logic              ex_rdEn2,
    output logic              ex_wrRegEn,
    output logic              ex_memRd,
    output logic              ex_memWr,
    output logic              ex_mem2reg,
    output logic              ex_sawBr,
    output logic              ex_sawJ,
    output logic              ex_addz,
    output logic              ex_aluSrc,
    output logic [3:0]        ex_aluOp,
    output logic [3:0]        ex_shAmt,
    output logic              halted
);

    localparam int CNT_W = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC + 1) : 1;

    logic [REG_AW-1:0] dRdReg1, dRdReg2, dWrReg;
    logic              dRdEn1, dRdEn2, dWrRegEn, dMemRd, dMemWr, dMem2reg;
    logic              dSawBr, dSawJ, dAddz, dAluSrc;
    logic [3:0]        dAluOp, dShAmt;
    logic [REG_AW-1:0] memWrReg;
    logic              memWrEn, memVld;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              exHit, memHit, rawStall, accept, hltIn;

    id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LINK_REG(LINK_REG)) u_dec (
        .instr(if_instr), .rdReg1(dRdReg1), .rdReg2(dRdReg2), .wrReg(dWrReg),
        .rdEn1(dRdEn1), .rdEn2(dRdEn2), .wrRegEn(dWrRegEn), .memRd(dMemRd),
        .memWr(dMemWr), .mem2reg(dMem2reg), .sawBr(dSawBr), .sawJ(dSawJ),
        .addz(dAddz), .aluSrc(dAluSrc), .aluOp(dAluOp), .shAmt(dShAmt)
    );

    // R0 is hardwired, so writes to it never create a dependency
    function automatic logic hit(input logic en, input logic [REG_AW-1:0] a,
                                 input logic [REG_AW-1:0] w, input logic wEn, input logic v);
        return en && wEn && v && a == w && a != '0;
    endfunction

    assign exHit    = hit(dRdEn1, dRdReg1, ex_wrReg, ex_wrRegEn, ex_vld)
                    | hit(dRdEn2, dRdReg2, ex_wrReg, ex_wrRegEn, ex_vld);
    assign memHit   = hit(dRdEn1, dRdReg1, memWrReg, memWrEn, memVld)
                    | hit(dRdEn2, dRdReg2, memWrReg, memWrEn, memVld);
    assign rawStall = if_vld & (HAZ_MODE != 0 ? exHit & ex_memRd : exHit | memHit);
    // a flush overrides a hazard stall so IF can redirect; drain/halt always holds IF
    assign id_stall = (state != ST_RUN) | (~ex_flush & rawStall);
    assign accept   = (state == ST_RUN) & ~ex_flush & ~rawStall & if_vld;
    assign hltIn    = opcode_t'(if_instr[DATA_W-1 -: 4]) == OP_HLT;
    assign halted   = state == ST_HALTED;

    // ID/EX register: load the decoded bundle on accept, otherwise issue a zeroed bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vld     <= 1'b0;
            ex_rdReg1  <= '0;
            ex_rdReg2  <= '0;
            ex_wrReg   <= '0;
            ex_rdEn1   <= 1'b0;
            ex_rdEn2   <= 1'b0;
            ex_wrRegEn <= 1'b0;
            ex_memRd   <= 1'b0;
            ex_memWr   <= 1'b0;
            ex_mem2reg <= 1'b0;
            ex_sawBr   <= 1'b0;
            ex_sawJ    <= 1'b0;
            ex_addz    <= 1'b0;
            ex_aluSrc  <= 1'b0;
            ex_aluOp   <= ALU_NOP;
            ex_shAmt   <= '0;
        end else begin
            ex_vld     <= accept;
            ex_rdReg1  <= accept ? dRdReg1 : '0;
            ex_rdReg2  <= accept ? dRdReg2 : '0;
            ex_wrReg   <= accept ? dWrReg : '0;
            ex_rdEn1   <= accept & dRdEn1;
            ex_rdEn2   <= accept & dRdEn2;
            ex_wrRegEn <= accept & dWrRegEn;
            ex_memRd   <= accept & dMemRd;
            ex_memWr   <= accept & dMemWr;
            ex_mem2reg <= accept & dMem2reg;
            ex_sawBr   <= accept & dSawBr;
            ex_sawJ    <= accept & dSawJ;
            ex_addz    <= accept & dAddz;
            ex_aluSrc  <= accept & dAluSrc;
            ex_aluOp   <= accept ? dAluOp : ALU_NOP;
            ex_shAmt   <= accept ? dShAmt : '0;
        end
    end

    // MEM-stage shadow of the destination, used for the no-forwarding hazard check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memWrReg <= '0;
            memWrEn  <= 1'b0;
            memVld   <= 1'b0;
        end else begin
            memWrReg <= ex_wrReg;
            memWrEn  <= ex_wrRegEn;
            memVld   <= ex_vld;
        end
    end

    // halt sequence: an accepted HLT drains EX/MEM/WB for DRAIN_CYC cycles, then halts for good
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else if (accept && hltIn) begin
            state <= ST_DRAIN;
            cnt   <= CNT_W'(DRAIN_CYC);
        end else if (state == ST_DRAIN) begin
            cnt <= cnt - 1'b1;
            if (cnt <= CNT_W'(1)) state <= ST_HALTED;
        end
    end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// tb_id_ctrl_pipe: table-driven decode checks plus hazard, flush and halt sequences with a scoreboard
module tb_id_ctrl_pipe;

    typedef struct packed {
        logic [3:0] r1, r2, w;
        logic [9:0] f;
        logic [3:0] op, sh;
    } exp_t;

    typedef struct packed {
        logic [15:0] instr;
        exp_t        e;
    } vec_t;

    // flag order: rdEn1 rdEn2 wrRegEn memRd memWr mem2reg sawBr sawJ addz aluSrc
    localparam exp_t E_IDLE  = {4'h0, 4'h0, 4'h0, 10'b0000000000, 4'hF, 4'h0};
    localparam exp_t E_LW4   = {4'h5, 4'h0, 4'h4, 10'b1011010000, 4'hF, 4'h0};
    localparam exp_t E_ADD6  = {4'h4, 4'h1, 4'h6, 10'b1110000001, 4'h0, 4'h1};
    localparam exp_t E_LW0   = {4'h5, 4'h0, 4'h0, 10'b1011010000, 4'hF, 4'h0};
    localparam exp_t E_ADD60 = {4'h0, 4'h1, 4'h6, 10'b1110000001, 4'h0, 4'h1};
    localparam exp_t E_ADD3  = {4'h1, 4'h2, 4'h3, 10'b1110000001, 4'h0, 4'h2};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr1, instr0;
    logic        vld1, vld0, fl1, fl0;

    logic       id_stall, ex_vld, ex_rdEn1, ex_rdEn2, ex_wrRegEn, ex_memRd, ex_memWr;
    logic       ex_mem2reg, ex_sawBr, ex_sawJ, ex_addz, ex_aluSrc, halted;
    logic [3:0] ex_rdReg1, ex_rdReg2, ex_wrReg, ex_aluOp, ex_shAmt;

    logic       z_stall, z_vld, z_rdEn1, z_rdEn2, z_wrRegEn, z_memRd, z_memWr;
    logic       z_mem2reg, z_sawBr, z_sawJ, z_addz, z_aluSrc, z_halted;
    logic [3:0] z_rdReg1, z_rdReg2, z_wrReg, z_aluOp, z_shAmt;

    exp_t got;
    exp_t q[$];
    vec_t tbl[15];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    assign got = {ex_rdReg1, ex_rdReg2, ex_wrReg, ex_rdEn1, ex_rdEn2, ex_wrRegEn, ex_memRd,
                  ex_memWr, ex_mem2reg, ex_sawBr, ex_sawJ, ex_addz, ex_aluSrc, ex_aluOp, ex_shAmt};

    id_ctrl_pipe #(.HAZ_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .if_instr(instr1), .if_vld(vld1), .ex_flush(fl1),
        .id_stall(id_stall), .ex_vld(ex_vld), .ex_rdReg1(ex_rdReg1), .ex_rdReg2(ex_rdReg2),
        .ex_wrReg(ex_wrReg), .ex_rdEn1(ex_rdEn1), .ex_rdEn2(ex_rdEn2), .ex_wrRegEn(ex_wrRegEn),
        .ex_memRd(ex_memRd), .ex_memWr(ex_memWr), .ex_mem2reg(ex_mem2reg), .ex_sawBr(ex_sawBr),
        .ex_sawJ(ex_sawJ), .ex_addz(ex_addz), .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp),
        .ex_shAmt(ex_shAmt), .halted(halted)
    );

    id_ctrl_pipe #(.HAZ_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .if_instr(instr0), .if_vld(vld0), .ex_flush(fl0),
        .id_stall(z_stall), .ex_vld(z_vld), .ex_rdReg1(z_rdReg1), .ex_rdReg2(z_rdReg2),
        .ex_wrReg(z_wrReg), .ex_rdEn1(z_rdEn1), .ex_rdEn2(z_rdEn2), .ex_wrRegEn(z_wrRegEn),
        .ex_memRd(z_memRd), .ex_memWr(z_memWr), .ex_mem2reg(z_mem2reg), .ex_sawBr(z_sawBr),
        .ex_sawJ(z_sawJ), .ex_addz(z_addz), .ex_aluSrc(z_aluSrc), .ex_aluOp(z_aluOp),
        .ex_shAmt(z_shAmt), .halted(z_halted)
    );

    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, g, e);
        end
    endtask

    task automatic step(input logic [15:0] i, input logic v, input logic f);
        @(negedge clk);
        instr1 = i;
        vld1   = v;
        fl1    = f;
        #1;
    endtask

    // scoreboard: every issued bundle must match the oldest expected one
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ex_vld) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected issue got=%0h", got);
            end else begin
                e = q.pop_front();
                chk("bundle", 32'(got), 32'(e));
            end
        end
    end

    initial begin
        tbl[0]  = {16'h0312, 4'h1, 4'h2, 4'h3, 10'b1110000001, 4'h0, 4'h2};
        tbl[1]  = {16'h1456, 4'h5, 4'h6, 4'h4, 10'b1110000011, 4'h0, 4'h6};
        tbl[2]  = {16'h2789, 4'h8, 4'h9, 4'h7, 10'b1110000001, 4'h1, 4'h9};
        tbl[3]  = {16'h3abc, 4'hb, 4'hc, 4'ha, 10'b1110000001, 4'h2, 4'hc};
        tbl[4]  = {16'h4123, 4'h2, 4'h3, 4'h1, 10'b1110000001, 4'h3, 4'h3};
        tbl[5]  = {16'h5564, 4'h6, 4'h4, 4'h5, 10'b1010000000, 4'h4, 4'h4};
        tbl[6]  = {16'h6671, 4'h7, 4'h1, 4'h6, 10'b1010000000, 4'h5, 4'h1};
        tbl[7]  = {16'h7782, 4'h8, 4'h2, 4'h7, 10'b1010000000, 4'h6, 4'h2};
        tbl[8]  = {16'h8450, 4'h5, 4'h0, 4'h4, 10'b1011010000, 4'hF, 4'h0};
        tbl[9]  = {16'h9123, 4'h1, 4'h3, 4'h1, 10'b1000100000, 4'hF, 4'h3};
        tbl[10] = {16'ha5ff, 4'h5, 4'hf, 4'h5, 10'b1010000000, 4'h7, 4'hf};
        tbl[11] = {16'hb612, 4'h1, 4'h2, 4'h6, 10'b0010000000, 4'hF, 4'h2};
        tbl[12] = {16'hc345, 4'h4, 4'h5, 4'h3, 10'b0000001000, 4'hF, 4'h5};
        tbl[13] = {16'hd123, 4'h2, 4'h3, 4'hf, 10'b0010000100, 4'hF, 4'h3};
        tbl[14] = {16'he070, 4'h7, 4'h0, 4'h0, 10'b1000000100, 4'hF, 4'h0};
        instr1 = '0; vld1 = 1'b0; fl1 = 1'b0;
        instr0 = '0; vld0 = 1'b0; fl0 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset bundle", 32'(got), 32'(E_IDLE));
        chk("reset vld", 32'(ex_vld), 0);
        chk("reset stall", 32'(id_stall), 0);
        chk("reset halted", 32'(halted), 0);
        @(negedge clk) rst_n = 1'b1;
        // decode of every non-halt opcode, back to back without hazards
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].instr, 1'b1, 1'b0);
            q.push_back(tbl[i].e);
            chk("table stall", 32'(id_stall), 0);
        end
        step(16'h0, 1'b0, 1'b0);
        step(16'h0, 1'b0, 1'b0);
        chk("table drained", 32'(q.size()), 0);
        // load-use: one stall, one bubble, then issue
        step(16'h8450, 1'b1, 1'b0);
        q.push_back(E_LW4);
        step(16'h0641, 1'b1, 1'b0);
        chk("load-use stall", 32'(id_stall), 1);
        step(16'h0641, 1'b1, 1'b0);
        chk("load-use bubble", 32'(ex_vld), 0);
        chk("load-use release", 32'(id_stall), 0);
        q.push_back(E_ADD6);
        // load into R0 never creates a hazard
        step(16'h8050, 1'b1, 1'b0);
        q.push_back(E_LW0);
        step(16'h0601, 1'b1, 1'b0);
        chk("r0 no stall", 32'(id_stall), 0);
        q.push_back(E_ADD60);
        step(16'h0, 1'b0, 1'b0);
        // flush on a stalled instruction: bubble and stall dropped
        step(16'h8450, 1'b1, 1'b0);
        q.push_back(E_LW4);
        step(16'h0641, 1'b1, 1'b1);
        chk("flush drops stall", 32'(id_stall), 0);
        step(16'h0, 1'b0, 1'b0);
        chk("flush bubble", 32'(ex_vld), 0);
        // HLT issues once, drains three cycles ignoring flush, then halts sticky
        step(16'hF000, 1'b1, 1'b0);
        q.push_back(E_IDLE);
        for (int i = 0; i < 3; i++) begin
            step(16'h0312, 1'b1, 1'(i == 1));
            chk("drain stall", 32'(id_stall), 1);
            chk("drain not halted", 32'(halted), 0);
            if (i > 0) chk("drain bubble", 32'(ex_vld), 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(16'h0312, 1'b1, 1'b0);
            chk("halted", 32'(halted), 1);
            chk("halted stall", 32'(id_stall), 1);
            chk("halted no issue", 32'(ex_vld), 0);
        end
        step(16'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset clears halt", 32'(halted), 0);
        @(negedge clk) rst_n = 1'b1;
        // HLT killed by flush leaves the FSM running
        step(16'hF000, 1'b1, 1'b1);
        chk("hlt flush stall", 32'(id_stall), 0);
        step(16'h0312, 1'b1, 1'b0);
        chk("hlt discarded", 32'(ex_vld), 0);
        chk("hlt flush no halt", 32'(halted), 0);
        chk("still running", 32'(id_stall), 0);
        q.push_back(E_ADD3);
        step(16'hF000, 1'b1, 1'b0);
        q.push_back(E_IDLE);
        // reset in the middle of a drain returns to RUN at once
        @(negedge clk);
        vld1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid-drain reset halted", 32'(halted), 0);
        chk("mid-drain reset vld", 32'(ex_vld), 0);
        chk("mid-drain reset stall", 32'(id_stall), 0);
        @(negedge clk) rst_n = 1'b1;
        // no forwarding: RAW stalls against EX, then against MEM
        @(negedge clk);
        instr0 = 16'h0211;
        vld0   = 1'b1;
        @(negedge clk);
        instr0 = 16'h2723;
        #1 chk("m0 ex stall", 32'(z_stall), 1);
        @(negedge clk);
        #1 chk("m0 mem stall", 32'(z_stall), 1);
        chk("m0 bubble", 32'(z_vld), 0);
        @(negedge clk);
        #1 chk("m0 release", 32'(z_stall), 0);
        @(negedge clk);
        vld0 = 1'b0;
        #1 chk("m0 issue vld", 32'(z_vld), 1);
        chk("m0 issue wrReg", 32'(z_wrReg), 7);
        chk("m0 issue rdReg1", 32'(z_rdReg1), 2);
        step(16'h0, 1'b0, 1'b0);
        step(16'h0, 1'b0, 1'b0);
        chk("scoreboard empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
